// File: rtl/ofm_writeback.sv
// ofm_writeback: requantises the convolution core's 16-bit result stream and writes it to OFM memory.
// Input sample -> stage 1 (ReLU + rounding add) -> stage 2 (shift + saturate) -> FWFT FIFO -> memory.
// Define OFM_WB_SATCNT_EN to add the sat_cnt output (per-frame saturation event counter).
module ofm_writeback #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 8,
    parameter int OFM_SIZE   = 12,
    parameter int CO         = 2,
    parameter int SHIFT      = 4,
    parameter int RELU       = 1,
    parameter int HWC        = 1,
    parameter int BASE_ADDR  = 0,
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk1,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  ofm_ready,
    output logic                  ofm_wr_en,
    output logic [ADDR_WIDTH-1:0] ofm_wr_addr,
    output logic [OUT_WIDTH-1:0]  ofm_wr_data,
    output logic                  busy,
    output logic                  done,
`ifdef OFM_WB_SATCNT_EN
    output logic [15:0]           sat_cnt,
`endif
    output logic                  err
);

    localparam int TOTAL = CO * OFM_SIZE * OFM_SIZE;
    localparam int TW    = $clog2(TOTAL + 1);
    localparam int COLW  = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;
    localparam int CHW   = (CO > 1) ? $clog2(CO) : 1;
    localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW  = $clog2(FIFO_DEPTH) + 1;
    localparam int EW    = ADDR_WIDTH + OUT_WIDTH;

    localparam logic [DATA_WIDTH:0] ROUND = {{DATA_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [COLW-1:0] col, row;
    logic [CHW-1:0]  ch;
    logic [TW-1:0]   in_cnt;

    logic                  s1_valid;
    logic signed [DATA_WIDTH:0] s1_sum;
    logic [ADDR_WIDTH-1:0] s1_addr;

    logic                  s2_valid;
    logic [OUT_WIDTH-1:0]  s2_data;
    logic [ADDR_WIDTH-1:0] s2_addr;

    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] fifo_cnt;
    logic            fifo_empty, fifo_full;
    logic [EW-1:0]   head;

    logic start_go, accept, s1_free, s1_load, s2_load, push, pop, drop;
    logic [DATA_WIDTH-1:0] x_relu;
    logic [31:0]           lin;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic signed [DATA_WIDTH:0] q_full;
    logic [DATA_WIDTH-OUT_WIDTH+1:0] q_upper;
    logic sat_pos, sat_neg;
    logic [OUT_WIDTH-1:0] q_sat;

    // Handshake chain: the two pipeline stages hold when the FIFO cannot take a word, so a
    // stalled memory fills FIFO plus both stages before an input is refused at stage 1.
    always_comb begin
        start_go   = (state == ST_IDLE) && start;
        fifo_empty = (fifo_cnt == '0);
        fifo_full  = (fifo_cnt == CNTW'(FIFO_DEPTH));
        pop        = !fifo_empty && ofm_ready;
        push       = s2_valid && (!fifo_full || pop);
        s2_load    = s1_valid && (!s2_valid || push);
        s1_free    = !s1_valid || s2_load;
        accept     = (state == ST_RUN) && in_valid;
        s1_load    = accept && s1_free;
        drop       = accept && !s1_free;
    end

    // Write address for the current input, from the raster counters.
    always_comb begin
        if (HWC != 0) begin
            lin = (32'(row) * 32'(OFM_SIZE) + 32'(col)) * 32'(CO) + 32'(ch);
        end else begin
            lin = 32'(ch) * 32'(OFM_SIZE * OFM_SIZE) + 32'(row) * 32'(OFM_SIZE) + 32'(col);
        end
        in_addr = ADDR_WIDTH'(lin + 32'(BASE_ADDR));
    end

    // Stage-1 combinational: optional ReLU before the rounding add.
    always_comb begin
        x_relu = in_data;
        if (RELU != 0 && in_data[DATA_WIDTH-1]) begin
            x_relu = '0;
        end
    end

    // Stage-2 combinational: arithmetic shift, then clip to the output range.
    always_comb begin
        q_full  = s1_sum >>> SHIFT;
        q_upper = q_full[DATA_WIDTH:OUT_WIDTH-1];
        sat_pos = !q_full[DATA_WIDTH] && (|q_upper);
        sat_neg = q_full[DATA_WIDTH] && !(&q_upper);
        if (sat_pos) begin
            q_sat = OUT_MAX;
        end else if (sat_neg) begin
            q_sat = OUT_MIN;
        end else begin
            q_sat = q_full[OUT_WIDTH-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state; DRAIN finishes in the cycle the last word leaves the FIFO.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (accept && in_cnt == TW'(TOTAL - 1)) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!s1_valid && !s2_valid &&
                    (fifo_empty || (fifo_cnt == CNTW'(1) && pop))) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Raster counters and accepted-input count; every accepted input counts, dropped or not.
    always_ff @(posedge clk1) begin
        if (rst || start_go) begin
            col    <= '0;
            row    <= '0;
            ch     <= '0;
            in_cnt <= '0;
        end else if (accept) begin
            in_cnt <= in_cnt + TW'(1);
            if (col == COLW'(OFM_SIZE - 1)) begin
                col <= '0;
                if (row == COLW'(OFM_SIZE - 1)) begin
                    row <= '0;
                    ch  <= (ch == CHW'(CO - 1)) ? '0 : ch + CHW'(1);
                end else begin
                    row <= row + COLW'(1);
                end
            end else begin
                col <= col + COLW'(1);
            end
        end
    end

    // Pipeline stage registers.
    always_ff @(posedge clk1) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_addr  <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_addr  <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_sum   <= {x_relu[DATA_WIDTH-1], x_relu} + ROUND;
                s1_addr  <= in_addr;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
            if (s2_load) begin
                s2_valid <= 1'b1;
                s2_data  <= q_sat;
                s2_addr  <= s1_addr;
            end else if (push) begin
                s2_valid <= 1'b0;
            end
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk1) begin
        if (push) begin
            mem[wr_ptr] <= {s2_addr, s2_data};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk1) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + CNTW'(1);
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - CNTW'(1);
            end
        end
    end

    // Sticky drop flag.
    always_ff @(posedge clk1) begin
        if (rst) begin
            err <= 1'b0;
        end else if (drop) begin
            err <= 1'b1;
        end
    end

`ifdef OFM_WB_SATCNT_EN
    // Saturation events in the current frame, counted as words enter stage 2.
    always_ff @(posedge clk1) begin
        if (rst || start_go) begin
            sat_cnt <= '0;
        end else if (s2_load && (sat_pos || sat_neg) && sat_cnt != 16'hFFFF) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end
`endif

    // Output drive: FIFO head when non-empty, zero otherwise.
    always_comb begin
        head        = mem[rd_ptr];
        ofm_wr_en   = pop;
        ofm_wr_addr = fifo_empty ? '0 : head[EW-1:OUT_WIDTH];
        ofm_wr_data = fifo_empty ? '0 : head[OUT_WIDTH-1:0];
        busy        = (state == ST_RUN) || (state == ST_DRAIN);
        done        = (state == ST_DONE);
    end

endmodule
